// File: rtl/bin_tape_loader.sv
// bin_tape_loader: BIN-format paper-tape loader for a 4K x 12 main RAM.
// It decodes leader, origin, data, field and rubout frames from the tape
// reader, writes the data words into RAM and checks the trailing checksum.
//
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset
//   start                  one-cycle pulse that begins a load from IDLE or DONE
//   rd_data/valid/ready    tape reader handshake (8-bit frames)
//   ram_we/addr/data       RAM write port (ram_we is a registered one-cycle pulse)
//   busy                   a load is in progress
//   done                   load finished (sticky until the next start)
//   cksum_err, frame_err   sticky error flags
//   word_count             data words written during this load (mod 4096)
module bin_tape_loader #(
  parameter logic [7:0] LEADER_CODE = 8'h80,
  parameter logic [7:0] RUBOUT_CODE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rd_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [11:0] ram_data,
  output logic        busy,
  output logic        done,
  output logic        cksum_err,
  output logic        frame_err,
  output logic [11:0] word_count
);

  typedef enum logic [2:0] {StIdle, StLeader, StFirst, StSecond, StCommit, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  hi6_q, hi6_d;
  logic [5:0]  lo6_q, lo6_d;
  logic        org_q, org_d;        // the pair being assembled is an origin
  logic        pend_valid_q, pend_valid_d;
  logic [11:0] pend_word_q, pend_word_d;
  logic        pend_org_q, pend_org_d;
  logic [11:0] sum_q, sum_d;
  logic        done_q, done_d;
  logic        cksum_err_q, cksum_err_d;
  logic        frame_err_q, frame_err_d;
  logic [11:0] count_q, count_d;
  logic [11:0] addr_q, addr_d;
  logic        we_q, we_d;

  logic        accept;
  logic        is_leader;
  logic        is_ignored;
  logic        is_first;
  logic [11:0] pend_fsum;

  assign accept     = rd_valid && rd_ready;
  assign is_leader  = (rd_data == LEADER_CODE);
  // Rubouts and field-setting frames never affect the load.
  assign is_ignored = (rd_data == RUBOUT_CODE) || (rd_data[7:6] == 2'b11);
  assign is_first   = !rd_data[7] && !is_leader && !is_ignored;

  // Frame sum of the pending word: raw first frame (origin bit included) plus second frame.
  assign pend_fsum = {5'd0, pend_org_q, pend_word_q[11:6]} + {6'd0, pend_word_q[5:0]};

  always_comb begin
    state_d      = state_q;
    hi6_d        = hi6_q;
    lo6_d        = lo6_q;
    org_d        = org_q;
    pend_valid_d = pend_valid_q;
    pend_word_d  = pend_word_q;
    pend_org_d   = pend_org_q;
    sum_d        = sum_q;
    done_d       = done_q;
    cksum_err_d  = cksum_err_q;
    frame_err_d  = frame_err_q;
    count_d      = count_q;
    addr_d       = addr_q;
    we_d         = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StLeader;
          sum_d        = '0;
          pend_valid_d = 1'b0;
          pend_word_d  = '0;
          pend_org_d   = 1'b0;
          done_d       = 1'b0;
          cksum_err_d  = 1'b0;
          frame_err_d  = 1'b0;
          count_d      = '0;
          addr_d       = '0;
        end
      end
      StLeader: begin
        if (accept && is_first) begin
          hi6_d   = rd_data[5:0];
          org_d   = rd_data[6];
          state_d = StSecond;
        end
      end
      StFirst: begin
        if (accept && !is_ignored) begin
          if (is_leader) begin
            // Trailer: the pending word is the checksum, never written or summed.
            cksum_err_d = (pend_word_q != sum_q);
            done_d      = 1'b1;
            state_d     = StDone;
          end else if (is_first) begin
            hi6_d   = rd_data[5:0];
            org_d   = rd_data[6];
            state_d = StSecond;
          end
        end
      end
      StSecond: begin
        if (accept && !is_ignored) begin
          if (rd_data[7]) begin
            frame_err_d = 1'b1;
            done_d      = 1'b1;
            state_d     = StDone;
          end else if (pend_valid_q) begin
            // A following pair proves the pending word is not the checksum.
            lo6_d   = rd_data[5:0];
            we_d    = !pend_org_q;
            state_d = StCommit;
          end else begin
            pend_word_d  = {hi6_q, rd_data[5:0]};
            pend_org_d   = org_q;
            pend_valid_d = 1'b1;
            state_d      = StFirst;
          end
        end
      end
      StCommit: begin
        sum_d = sum_q + pend_fsum;
        if (pend_org_q) begin
          addr_d = pend_word_q;
        end else begin
          addr_d  = addr_q + 12'd1;
          count_d = count_q + 12'd1;
        end
        pend_word_d = {hi6_q, lo6_q};
        pend_org_d  = org_q;
        state_d     = StFirst;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hi6_q        <= '0;
      lo6_q        <= '0;
      org_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= '0;
      pend_org_q   <= 1'b0;
      sum_q        <= '0;
      done_q       <= 1'b0;
      cksum_err_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      count_q      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi6_q        <= hi6_d;
      lo6_q        <= lo6_d;
      org_q        <= org_d;
      pend_valid_q <= pend_valid_d;
      pend_word_q  <= pend_word_d;
      pend_org_q   <= pend_org_d;
      sum_q        <= sum_d;
      done_q       <= done_d;
      cksum_err_q  <= cksum_err_d;
      frame_err_q  <= frame_err_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
    end
  end

  assign rd_ready   = (state_q == StLeader) || (state_q == StFirst) || (state_q == StSecond);
  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_data   = pend_word_q;  // the word being committed is always the pending one
  assign done       = done_q;
  assign cksum_err  = cksum_err_q;
  assign frame_err  = frame_err_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_bin_tape_loader.sv
// Self-checking bench for bin_tape_loader: table of tapes with expected
// results, a write scoreboard fed from the table, and a reset-mid-load sequence.
module tb_bin_tape_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [11:0] ram_data;
  logic        busy;
  logic        done;
  logic        cksum_err;
  logic        frame_err;
  logic [11:0] word_count;

  bin_tape_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .busy       (busy),
    .done       (done),
    .cksum_err  (cksum_err),
    .frame_err  (frame_err),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] tape;   // frames right-aligned: frame 0 is the most significant
    int           len;
    bit           junk;   // insert FF and C8 before every frame, random rd_valid gaps
    int           nw;
    logic [11:0]  wa0;
    logic [11:0]  wd0;
    logic [11:0]  wa1;
    logic [11:0]  wd1;
    bit           e_cksum;
    bit           e_frame;
    logic [11:0]  e_count;
  } case_t;

  case_t       cases [5];
  logic [23:0] sb [$];    // expected {addr, data} of each RAM write
  logic [11:0] mem [4096];
  int          tests = 0;
  int          fails = 0;

  function automatic case_t mk(input logic [127:0] t, input int n, input bit j, input int nw,
                               input logic [11:0] a0, input logic [11:0] d0,
                               input logic [11:0] a1, input logic [11:0] d1,
                               input bit ec, input bit ef, input logic [11:0] cnt);
    case_t c;
    c.tape = t; c.len = n; c.junk = j; c.nw = nw;
    c.wa0 = a0; c.wd0 = d0; c.wa1 = a1; c.wd1 = d1;
    c.e_cksum = ec; c.e_frame = ef; c.e_count = cnt;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && ram_we) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addr, ram_data);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        if ({ram_addr, ram_data} !== e) begin
          fails++;
          $display("FAIL ram_write: got %h<-%h expected %h<-%h",
                   ram_addr, ram_data, e[23:12], e[11:0]);
        end
      end
      mem[ram_addr] = ram_data;
    end
  end

  // Called at a negedge; returns at the negedge after the frame is accepted.
  task automatic send(input logic [7:0] f, input bit rnd);
    int t;
    bit ok;
    if (rnd) begin
      rd_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rd_data  = f;
    rd_valid = 1'b1;
    ok = 1'b0;
    for (t = 0; t < 20 && !ok; t++) begin
      if (rd_ready) ok = 1'b1;
      @(negedge clk);
    end
    rd_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: frame %h not accepted within 20 cycles", f);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_cleared", {31'd0, done}, 32'd0);
  endtask

  task automatic run_case(input int k);
    case_t c;
    c = cases[k];
    if (c.nw > 0) sb.push_back({c.wa0, c.wd0});
    if (c.nw > 1) sb.push_back({c.wa1, c.wd1});
    pulse_start();
    for (int i = 0; i < c.len; i++) begin
      if (c.junk) begin
        send(8'hFF, 1'b1);
        send(8'hC8, 1'b1);
      end
      send(c.tape[8*(c.len-1-i) +: 8], c.junk);
    end
    chk($sformatf("c%0d_done", k), {31'd0, done}, 32'd1);
    chk($sformatf("c%0d_cksum_err", k), {31'd0, cksum_err}, {31'd0, c.e_cksum});
    chk($sformatf("c%0d_frame_err", k), {31'd0, frame_err}, {31'd0, c.e_frame});
    chk($sformatf("c%0d_word_count", k), {20'd0, word_count}, {20'd0, c.e_count});
    chk($sformatf("c%0d_idle_flags", k), {30'd0, busy, rd_ready}, 32'd0);
    chk($sformatf("c%0d_writes_left", k), sb.size(), 32'd0);
    sb.delete();
    if (c.nw > 0) chk($sformatf("c%0d_mem0", k), {20'd0, mem[c.wa0]}, {20'd0, c.wd0});
    if (c.nw > 1) chk($sformatf("c%0d_mem1", k), {20'd0, mem[c.wa1]}, {20'd0, c.wd1});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // nominal, bad checksum, frame error, nominal with junk, address wrap
    cases[0] = mk(128'({8'h80, 8'h80, 8'h80, 8'h80, 8'h41, 8'h00, 8'h3F, 8'h3F, 8'h00, 8'h01,
                        8'h03, 8'h00, 8'h80}), 13, 1'b0, 2,
                  12'h040, 12'hFFF, 12'h041, 12'h001, 1'b0, 1'b0, 12'd2);
    cases[1] = mk(128'({8'h80, 8'h80, 8'h80, 8'h80, 8'h41, 8'h00, 8'h3F, 8'h3F, 8'h00, 8'h01,
                        8'h03, 8'h01, 8'h80}), 13, 1'b0, 2,
                  12'h040, 12'hFFF, 12'h041, 12'h001, 1'b1, 1'b0, 12'd2);
    cases[2] = mk(128'({8'h80, 8'h41, 8'h80}), 3, 1'b0, 0,
                  12'h0, 12'h0, 12'h0, 12'h0, 1'b0, 1'b1, 12'd0);
    cases[3] = cases[0];
    cases[3].junk = 1'b1;
    cases[4] = mk(128'({8'h80, 8'h80, 8'h7F, 8'h3F, 8'h00, 8'h05, 8'h00, 8'h06, 8'h03, 8'h09,
                        8'h80}), 11, 1'b0, 2,
                  12'hFFF, 12'h005, 12'h000, 12'h006, 1'b0, 1'b0, 12'd2);

    for (int i = 0; i < 4096; i++) mem[i] = 12'h0;
    rst_n = 1'b0; start = 1'b0; rd_data = 8'h00; rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_ready, ram_we, ram_addr, ram_data, busy, done, cksum_err,
                          frame_err, word_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_busy", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 5; k++) run_case(k);

    // Reset during the bubble that writes the second data word.
    sb.push_back({12'h040, 12'hFFF});
    sb.push_back({12'h041, 12'h001});
    pulse_start();
    send(8'h80, 1'b0); send(8'h41, 1'b0); send(8'h00, 1'b0);
    send(8'h3F, 1'b0); send(8'h3F, 1'b0);
    send(8'h00, 1'b0); send(8'h01, 1'b0);
    send(8'h03, 1'b0); send(8'h00, 1'b0);
    chk("commit_we_high", {31'd0, ram_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_we", {31'd0, ram_we}, 32'd0);
    chk("midload_reset_outputs", {rd_ready, ram_we, ram_addr, ram_data, busy, done, cksum_err,
                                  frame_err, word_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midload_writes_seen", sb.size(), 32'd0);
    sb.delete();
    run_case(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
